byte_stream_packer: RTL and testbench

BYTE_STREAM_PACKER -- requirements
Module: byte_stream_packer

---
 rtl/lynxTypes.sv | 25 ++
 rtl/AXI4S.sv | 15 +
 rtl/byte_left_shifter.sv | 12 +
 rtl/byte_stream_packer.sv | 143 ++++++++++++++
 tb/tb_byte_stream_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lynxTypes.sv
// Shared types and helpers for the AXI4-Stream byte packer.
package lynxTypes;

    // Upper bound on bytes per beat handled by the helper functions.
    localparam int MAX_BYTES = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    // Number of consecutive set keep bits starting at byte 0, limited to nbytes.
    function automatic int lead_ones(input logic [MAX_BYTES-1:0] keep, input int nbytes);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && run && keep[i]) cnt++;
            else run = 1'b0;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/AXI4S.sv
// Minimal AXI4-Stream bundle with master/slave views.
interface AXI4S #(
    parameter int WIDTH = 512
) ();
    localparam int BYTES = WIDTH / 8;

    logic [WIDTH-1:0] tdata;
    logic [BYTES-1:0] tkeep;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport m (output tdata, tkeep, tlast, tvalid, input tready);
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/byte_left_shifter.sv
// Zero-extends a beat to double width and shifts it left by a whole number of bytes.
module byte_left_shifter #(
    parameter int WIDTH   = 512,
    parameter int BYTES   = WIDTH / 8,
    parameter int SHIFT_W = $clog2(BYTES)
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [2*WIDTH-1:0] data_o
);
    assign data_o = {{WIDTH{1'b0}}, data_i} << {shift_i, 3'b000};
endmodule

// File: rtl/byte_stream_packer.sv
// Packs sparse AXI4-Stream beats (leading-ones tkeep) into dense full-width beats,
// keeping packet boundaries and splitting an overflowing last beat into two.
module byte_stream_packer
    import lynxTypes::*;
#(
    parameter int WIDTH     = 512,
    parameter int BYTES     = WIDTH / 8,
    parameter int CNT_WIDTH = $clog2(BYTES) + 1
) (
    input  logic aclk,
    input  logic aresetn,
    AXI4S.s      i_data,
    AXI4S.m      o_data,
    output logic o_error
);
    localparam int RW      = (BYTES - 1) * 8;
    localparam int SHIFT_W = $clog2(BYTES);

    pack_state_e          state_q, state_d;
    logic [RW-1:0]        res_q, res_d;
    logic [CNT_WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0]     tdata_q, tdata_d;
    logic [BYTES-1:0]     tkeep_q, tkeep_d;
    logic                 tlast_q, tlast_d;
    logic                 tvalid_q, tvalid_d;
    logic                 err_q, err_d;

    logic [CNT_WIDTH-1:0] in_cnt;
    logic [CNT_WIDTH:0]   total;
    logic [BYTES-1:0]     in_mask, tot_mask, fill_mask;
    logic [WIDTH-1:0]     in_clean;
    logic [2*WIDTH-1:0]   shifted, merged;
    logic                 out_free, in_ready, accept, non_contig;
    logic                 unused_hi;

    assign in_cnt     = CNT_WIDTH'(lead_ones(MAX_BYTES'(i_data.tkeep), BYTES));
    assign non_contig = (i_data.tkeep != in_mask);
    assign total      = {1'b0, fill_q} + {1'b0, in_cnt};

    // Bytes past the first keep hole are dropped so residue and outputs stay zero-padded.
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
        assign in_mask[b]          = (b < int'(in_cnt));
        assign tot_mask[b]         = (b < int'(total));
        assign fill_mask[b]        = (b < int'(fill_q));
        assign in_clean[8*b +: 8]  = in_mask[b] ? i_data.tdata[8*b +: 8] : 8'h00;
    end

    byte_left_shifter #(
        .WIDTH   (WIDTH),
        .BYTES   (BYTES),
        .SHIFT_W (SHIFT_W)
    ) u_shift (
        .data_i  (in_clean),
        .shift_i (fill_q[SHIFT_W-1:0]),
        .data_o  (shifted)
    );

    // The residue is at most BYTES-1 bytes, so the top merged byte is always zero.
    assign merged    = shifted | {{(2*WIDTH-RW){1'b0}}, res_q};
    assign unused_hi = ^merged[2*WIDTH-1 -: 8];

    assign out_free        = !tvalid_q || o_data.tready;
    assign in_ready        = aresetn && (state_q == ACCUM) && out_free;
    assign accept          = i_data.tvalid && in_ready;
    assign i_data.tready   = in_ready;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        fill_d   = fill_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q && !o_data.tready;
        err_d    = err_q || (accept && non_contig);
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (i_data.tlast && int'(total) <= BYTES) begin
                        tdata_d  = merged[WIDTH-1:0];
                        tkeep_d  = tot_mask;
                        tlast_d  = 1'b1;
                        tvalid_d = 1'b1;
                        res_d    = '0;
                        fill_d   = '0;
                    end else if (int'(total) >= BYTES) begin
                        tdata_d  = merged[WIDTH-1:0];
                        tkeep_d  = '1;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b1;
                        res_d    = merged[WIDTH +: RW];
                        fill_d   = CNT_WIDTH'(int'(total) - BYTES);
                        if (i_data.tlast) state_d = FLUSH;
                    end else begin
                        res_d  = merged[RW-1:0];
                        fill_d = total[CNT_WIDTH-1:0];
                    end
                end
            end
            FLUSH: begin
                // Tail of a split last beat goes out as soon as the register frees up.
                if (out_free) begin
                    tdata_d  = {8'h00, res_q};
                    tkeep_d  = fill_mask;
                    tlast_d  = 1'b1;
                    tvalid_d = 1'b1;
                    res_d    = '0;
                    fill_d   = '0;
                    state_d  = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ACCUM;
            res_q    <= '0;
            fill_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            fill_q   <= fill_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            err_q    <= err_d;
        end
    end

    assign o_data.tdata  = tdata_q;
    assign o_data.tkeep  = tkeep_q;
    assign o_data.tlast  = tlast_q;
    assign o_data.tvalid = tvalid_q;
    assign o_error       = err_q;
endmodule

// File: tb/tb_byte_stream_packer.sv
// Bench for byte_stream_packer: vector table, corner sequences and random traffic
// scored against a byte-queue model of the packing rules.
module tb_byte_stream_packer;
    localparam int WIDTH = 512;
    localparam int BYTES = 64;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [BYTES-1:0] keep;
        logic             last;
    } beat_t;

    typedef struct {
        int nin;
        int n0, n1, n2;
        int exp_beats;
        int exp_last_cnt;
    } vec_t;

    logic aclk = 1'b0;
    logic aresetn;
    logic o_error;

    AXI4S #(.WIDTH(WIDTH)) ibus ();
    AXI4S #(.WIDTH(WIDTH)) obus ();

    byte_stream_packer #(.WIDTH(WIDTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_data  (ibus),
        .o_data  (obus),
        .o_error (o_error)
    );

    always #5 aclk = ~aclk;

    beat_t      in_q[$];
    beat_t      got_q[$];
    beat_t      exp_q[$];
    logic [7:0] acc[$];
    logic       exp_err = 1'b0;
    logic [7:0] seq = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         rdy_mode = 1;
    int         gap_pct = 0;
    int         acc_cnt = 0;
    logic       in_hs = 1'b0;

    function automatic logic [BYTES-1:0] lowm(input int n);
        logic [BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int lead(input logic [BYTES-1:0] k);
        int c;
        c = 0;
        while (c < BYTES && k[c]) c++;
        return c;
    endfunction

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic emit(input int cnt, input logic last);
        beat_t e;
        e.data = '0;
        e.keep = '0;
        e.last = last;
        for (int i = 0; i < cnt; i++) begin
            e.data[8*i +: 8] = acc.pop_front();
            e.keep[i] = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Reference: bytes stream into a queue; full beats leave as they fill, tlast drains it.
    task automatic model_push(input beat_t b);
        int n;
        n = lead(b.keep);
        if (b.keep != lowm(n)) exp_err = 1'b1;
        for (int i = 0; i < n; i++) acc.push_back(b.data[8*i +: 8]);
        while (acc.size() > BYTES || (acc.size() == BYTES && !b.last)) emit(BYTES, 1'b0);
        if (b.last) emit(acc.size(), 1'b1);
    endtask

    task automatic send_raw(input logic [BYTES-1:0] keep, input logic last);
        beat_t b;
        b.keep = keep;
        b.last = last;
        for (int i = 0; i < BYTES; i++) begin
            if (keep[i]) begin
                b.data[8*i +: 8] = seq;
                seq = seq + 8'd1;
            end else begin
                b.data[8*i +: 8] = 8'($urandom);
            end
        end
        in_q.push_back(b);
        model_push(b);
    endtask

    task automatic send(input int n, input logic last);
        send_raw(lowm(n), last);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((in_q.size() != 0 || ibus.tvalid || obus.tvalid) && k < budget) begin
            @(posedge aclk);
            #2;
            k++;
        end
        repeat (2) @(posedge aclk);
        #2;
        chk({name, " drain cycles"}, k < budget, k, budget);
    endtask

    task automatic compare(input string name);
        beat_t g, e;
        int    idx;
        idx = 0;
        chk({name, " beat count"}, got_q.size() == exp_q.size(), got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g.data !== e.data || g.keep !== e.keep || g.last !== e.last) begin
                errors++;
                $display("FAIL %s beat %0d: got keep=%h last=%b data=%h required keep=%h last=%b data=%h",
                         name, idx, g.keep, g.last, g.data, e.keep, e.last, e.data);
            end
            idx++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " tvalid"}, obus.tvalid == 1'b0, obus.tvalid, 0);
        chk({name, " tdata/tkeep/tlast"},
            obus.tdata == '0 && obus.tkeep == '0 && obus.tlast == 1'b0,
            $countones(obus.tdata) + $countones(obus.tkeep) + obus.tlast, 0);
        chk({name, " tready"}, ibus.tready == 1'b0, ibus.tready, 0);
        chk({name, " o_error"}, o_error == 1'b0, o_error, 0);
    endtask

    // Input driver and output-ready generator; changes land 1ns after the rising edge.
    initial begin
        beat_t b;
        ibus.tvalid = 1'b0;
        ibus.tdata  = '0;
        ibus.tkeep  = '0;
        ibus.tlast  = 1'b0;
        obus.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn || in_hs) ibus.tvalid = 1'b0;
            if (aresetn && !ibus.tvalid && in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                b = in_q.pop_front();
                ibus.tdata  = b.data;
                ibus.tkeep  = b.keep;
                ibus.tlast  = b.last;
                ibus.tvalid = 1'b1;
            end
            case (rdy_mode)
                0:       obus.tready = 1'b0;
                1:       obus.tready = 1'b1;
                default: obus.tready = ($urandom_range(99) < 60);
            endcase
        end
    end

    // Monitor: on the falling edge, a valid&ready pair is what the next rising edge transfers.
    initial begin
        beat_t g;
        forever begin
            @(negedge aclk);
            in_hs = aresetn && ibus.tvalid && ibus.tready;
            if (in_hs) acc_cnt++;
            if (aresetn && obus.tvalid && obus.tready) begin
                g.data = obus.tdata;
                g.keep = obus.tkeep;
                g.last = obus.tlast;
                got_q.push_back(g);
            end
        end
    end

    initial begin
        vec_t             vecs[10];
        logic [WIDTH-1:0] snap_d;
        logic [BYTES-1:0] snap_k;
        int               base, k, r, n, stable_bad;
        logic             last, seen;

        vecs[0] = '{3, 32, 32, 64, 2, 64};
        vecs[1] = '{2, 40, 40, 0, 2, 16};
        vecs[2] = '{1, 0, 0, 0, 1, 0};
        vecs[3] = '{2, 64, 0, 0, 2, 0};
        vecs[4] = '{2, 63, 1, 0, 1, 64};
        vecs[5] = '{2, 63, 2, 0, 2, 1};
        vecs[6] = '{2, 10, 20, 0, 1, 30};
        vecs[7] = '{3, 64, 64, 63, 3, 63};
        vecs[8] = '{3, 63, 63, 63, 3, 61};
        vecs[9] = '{1, 64, 0, 0, 1, 64};

        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        @(posedge aclk);
        #2;
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].nin == 1) send(vecs[i].n0, 1'b1);
            else begin
                send(vecs[i].n0, 1'b0);
                if (vecs[i].nin == 3) send(vecs[i].n1, 1'b0);
                send(vecs[i].nin == 3 ? vecs[i].n2 : vecs[i].n1, 1'b1);
            end
            drain($sformatf("vec%0d", i), 500);
            chk($sformatf("vec%0d out beats", i), got_q.size() == vecs[i].exp_beats,
                got_q.size(), vecs[i].exp_beats);
            if (got_q.size() > 0)
                chk($sformatf("vec%0d last beat bytes", i),
                    $countones(got_q[got_q.size()-1].keep) == vecs[i].exp_last_cnt && got_q[got_q.size()-1].last,
                    $countones(got_q[got_q.size()-1].keep), vecs[i].exp_last_cnt);
            compare($sformatf("vec%0d", i));
        end

        // Split last beat: input stalls for exactly the one FLUSH cycle.
        send(40, 1'b0);
        send(40, 1'b1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 50) begin
            @(negedge aclk);
            seen = ibus.tvalid && ibus.tready && ibus.tlast;
            k++;
        end
        chk("flush last accepted", seen, seen, 1);
        @(negedge aclk);
        chk("flush tready low", ibus.tready == 1'b0, ibus.tready, 0);
        @(negedge aclk);
        chk("flush tready back", ibus.tready == 1'b1, ibus.tready, 1);
        drain("flush", 500);
        compare("flush");

        // Backpressure: output held stable, at most one input taken while blocked.
        @(posedge aclk);
        #2;
        base = acc_cnt;
        rdy_mode = 0;
        send(64, 1'b0);
        send(64, 1'b0);
        send(64, 1'b0);
        send(8, 1'b1);
        repeat (3) @(negedge aclk);
        snap_d = obus.tdata;
        snap_k = obus.tkeep;
        stable_bad = 0;
        repeat (10) begin
            @(negedge aclk);
            if (!obus.tvalid || obus.tdata !== snap_d || obus.tkeep !== snap_k) stable_bad++;
        end
        chk("hold output stable", stable_bad == 0, stable_bad, 0);
        @(posedge aclk);
        #2;
        chk("hold inputs taken <=1", acc_cnt - base <= 1, acc_cnt - base, 1);
        rdy_mode = 2;
        drain("hold", 1000);
        compare("hold");
        rdy_mode = 1;

        // Non-contiguous keep: only the leading run counts, error flag sticks.
        chk("error clear before", o_error == 1'b0, o_error, 0);
        send_raw(64'h0000_0000_0000_0F0F, 1'b1);
        drain("holes", 500);
        compare("holes");
        chk("error set", o_error == 1'b1, o_error, 1);
        send(16, 1'b1);
        drain("after holes", 500);
        compare("after holes");
        chk("error sticky", o_error == 1'b1, o_error, 1);

        // Reset with 20 bytes of residue pending.
        send(20, 1'b0);
        drain("residue", 500);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        in_q.delete();
        acc.delete();
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge aclk);
        check_reset_outputs("mid reset");
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        send(8, 1'b1);
        drain("post reset", 500);
        chk("post reset beats", got_q.size() == 1, got_q.size(), 1);
        if (got_q.size() > 0)
            chk("post reset bytes", $countones(got_q[0].keep) == 8, $countones(got_q[0].keep), 8);
        compare("post reset");

        // Random traffic with gaps and random output backpressure.
        rdy_mode = 2;
        gap_pct = 30;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 25) n = 64;
            else if (r < 35) n = 0;
            else n = $urandom_range(64);
            last = ($urandom_range(99) < 20) || (i == 299);
            if ($urandom_range(99) < 5) send_raw({$urandom, $urandom}, last);
            else send(n, last);
        end
        drain("random", 5000);
        compare("random");
        chk("random error flag", o_error == exp_err, o_error, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
